// File: rtl/div_radix2_if.sv
// Handshake bundle between the E stage and the radix-2 divider.
// master: pipeline side (start/operands/hold/annul); slave: divider side (result/ready/stall_div).
interface div_radix2_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic               signed_div;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               hold;
   logic               annul;
   logic [2*WIDTH-1:0] result;
   logic               ready;
   logic               stall_div;

   modport master (
      output start, signed_div, a, b, hold, annul,
      input  result, ready, stall_div
   );

   modport slave (
      input  start, signed_div, a, b, hold, annul,
      output result, ready, stall_div
   );
endinterface

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the E stage; result = {rem, quo}.
// Ports: clk, rst (sync, active-high), bus (div_radix2_if.slave). Option: DIV_EARLY_OUT_EN.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   div_radix2_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]   rem, quo, dvs;
   logic               sdiv, sgn_a, sgn_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] res;

   logic load, step, fin, rdy, stall;

   logic [WIDTH-1:0] amag, bmag;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic [WIDTH-1:0] fin_rem, fin_quo;
   logic [WIDTH-1:0] cor_rem, cor_quo;

`ifdef DIV_EARLY_OUT_EN
   logic early;
   // quo still holds |a| on the first BUSY cycle
   assign early = (cnt == '0) && ((dvs == '0) || (quo < dvs));
`endif

   assign amag = (bus.signed_div & bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign bmag = (bus.signed_div & bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // rem < dvs always holds, so the shifted value fits in WIDTH+1 bits
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs};
   assign rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nx  = {quo[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      fin_rem = rem_nx;
      fin_quo = quo_nx;
`ifdef DIV_EARLY_OUT_EN
      if (early) begin
         fin_rem = quo;
         fin_quo = (dvs == '0) ? '1 : '0;
      end
`endif
   end

   assign cor_rem = (sdiv & sgn_a) ? -fin_rem : fin_rem;
   assign cor_quo = (sdiv & sgn_q) ? -fin_quo : fin_quo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      fin      = 1'b0;
      rdy      = 1'b0;
      stall    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               stall    = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            step  = 1'b1;
            if (cnt == LAST) begin
               fin      = 1'b1;
               state_nx = DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
               step     = 1'b0;
               fin      = 1'b1;
               state_nx = DONE;
            end
`endif
         end
         DONE: begin
            rdy = 1'b1;
            if (!bus.hold) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // flush kills everything, including a start in the same cycle
      if (bus.annul) begin
         state_nx = IDLE;
         load     = 1'b0;
         step     = 1'b0;
         fin      = 1'b0;
         rdy      = 1'b0;
         stall    = 1'b0;
      end
      if (rst) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         sdiv  <= 1'b0;
         sgn_a <= 1'b0;
         sgn_q <= 1'b0;
         cnt   <= '0;
         res   <= '0;
      end else begin
         if (load) begin
            rem   <= '0;
            quo   <= amag;
            dvs   <= bmag;
            sdiv  <= bus.signed_div;
            sgn_a <= bus.a[WIDTH-1];
            sgn_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            cnt   <= '0;
         end else if (step) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CW'(1);
         end
         if (fin) begin
            res <= {cor_rem, cor_quo};
         end
      end
   end

   assign bus.result    = res;
   assign bus.ready     = rdy;
   assign bus.stall_div = stall;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases plus random DIV/DIVU.
// Reference model uses plain SV arithmetic on the operands.
module tb_div_radix2;

   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   div_radix2_if #(.WIDTH(W)) bus ();

   div_radix2 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 0) begin
         r = a;
         q = (sd && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (!sd) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {r, q};
   endfunction

   function automatic int exp_lat(input bit sd, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ma, mb;
      bit early;
      sa = sd ? longint'($signed(a)) : longint'(a);
      sb = sd ? longint'($signed(b)) : longint'(b);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      early = (b == 0) || (ma < mb);
      return (EO && early) ? 2 : 33;
   endfunction

   task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input int hold_n, input string tag);
      logic [63:0] exp_r;
      int lat, n;
      exp_r = ref_div(sd, a, b);
      lat   = exp_lat(sd, a, b);
      bus.signed_div = sd;
      bus.a          = a;
      bus.b          = b;
      bus.start      = 1'b1;
      bus.hold       = 1'b0;
      bus.annul      = 1'b0;
      #1;
      chk({tag, " stall0"}, 64'(bus.stall_div), 64'd1);
      n = 0;
      while (!bus.ready && n < 100) begin
         tick();
         n++;
         if (!bus.ready) chk({tag, " stall_busy"}, 64'(bus.stall_div), 64'd1);
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " result"}, bus.result, exp_r);
      chk({tag, " stall_done"}, 64'(bus.stall_div), 64'd0);
      if (hold_n > 0) begin
         bus.hold = 1'b1;
         for (int i = 0; i < hold_n; i++) begin
            tick();
            chk({tag, " hold_ready"}, 64'(bus.ready), 64'd1);
            chk({tag, " hold_result"}, bus.result, exp_r);
         end
         bus.hold = 1'b0;
      end
      tick();
      bus.start = 1'b0;
      #1;
      chk({tag, " idle_ready"}, 64'(bus.ready), 64'd0);
      chk({tag, " idle_stall"}, 64'(bus.stall_div), 64'd0);
   endtask

   initial begin
      bit sd;
      logic [31:0] ra, rb;
      int mode;

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.hold       = 1'b0;
      bus.annul      = 1'b0;
      tick();
      tick();
      chk("reset result", bus.result, 64'd0);
      chk("reset ready", 64'(bus.ready), 64'd0);
      chk("reset stall", 64'(bus.stall_div), 64'd0);
      rst = 1'b0;
      tick();

      chk("ref 100/7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      run_div(1'b0, 32'd100, 32'd7, 0, "divu100_7");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div-7_2");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_div(1'b0, 32'd5, 32'd0, 0, "divu5_0");
      run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, "div-5_0");
      run_div(1'b1, 32'd3, 32'hFFFF_FFF0, 0, "div_small");
      run_div(1'b0, 32'd100, 32'd7, 4, "hold");

      // annul mid-operation, start held in the annul cycle
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.start      = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      bus.annul = 1'b1;
      #1;
      chk("annul stall", 64'(bus.stall_div), 64'd0);
      chk("annul ready", 64'(bus.ready), 64'd0);
      tick();
      bus.annul = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("post_annul stall", 64'(bus.stall_div), 64'd0);
      chk("post_annul ready", 64'(bus.ready), 64'd0);
      tick();
      run_div(1'b0, 32'd9, 32'd3, 0, "after_annul");

      // reset mid-operation with start held high
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.start      = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid result", bus.result, 64'd0);
      chk("rst_mid ready", 64'(bus.ready), 64'd0);
      chk("rst_mid stall", 64'(bus.stall_div), 64'd0);
      tick();
      rst = 1'b0;
      run_div(1'b0, 32'd100, 32'd7, 0, "after_rst");

      for (int k = 0; k < 24; k++) begin
         sd   = 1'($urandom_range(0, 1));
         ra   = $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = $urandom;
            default: begin
               rb = $urandom;
               ra = 32'($urandom_range(0, 1000));
            end
         endcase
         run_div(sd, ra, rb, $urandom_range(0, 2), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
